// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: writeback stage that captures a memory-stage result, selects the
// register-file write value, holds ecalls for the environment and counts retirements.
module mem_wb_writeback #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memory_done,
    input  logic [XLEN-1:0]       mem_alu_data,
    input  logic [XLEN-1:0]       mem_load_data,
    input  logic [XLEN-1:0]       mem_pc_plus4,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [1:0]            mem_wb_sel,
    input  logic                  mem_is_ecall,
    input  logic                  ecall_done,
    input  logic [XLEN-1:0]       ecall_a0,
    output logic                  mem_wb_pipeline_valid,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  wb_clear_valid,
    output logic [REG_ADDR_W-1:0] wb_clear_rd,
    output logic                  ecall_request,
    output logic                  retire_pulse,
    output logic [CNT_W-1:0]      retire_count
);
    typedef enum logic [1:0] {IDLE, FULL, ECALL_WAIT, DRAIN} state_t;
    state_t                state_q, state_d;
    logic [XLEN-1:0]       alu_q, load_q, pc4_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  reg_write_q, is_ecall_q;
    logic [1:0]            wb_sel_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  capture, retire, ecall_finish;
    logic [XLEN-1:0]       sel_data;

    always_comb begin
        capture      = state_q == IDLE && memory_done;
        ecall_finish = state_q == ECALL_WAIT && ecall_done;
        retire       = (state_q == FULL && !is_ecall_q) || ecall_finish;
        sel_data     = wb_sel_q == 2'd1 ? load_q : wb_sel_q == 2'd2 ? pc4_q : alu_q;
        // DRAIN waits for memory_done to drop so a held result is never recaptured
        state_d      = state_q == IDLE       ? (memory_done ? FULL : IDLE)
                     : state_q == FULL       ? (is_ecall_q ? ECALL_WAIT : DRAIN)
                     : state_q == ECALL_WAIT ? (ecall_done ? DRAIN : ECALL_WAIT)
                     :                         (memory_done ? DRAIN : IDLE);
        count_d      = count_q + CNT_W'(retire);
    end

    assign mem_wb_pipeline_valid = state_q != IDLE;
    assign rf_we                 = retire && reg_write_q && rd_q != '0;
    assign rf_waddr              = rd_q;
    assign rf_wdata              = ecall_finish ? ecall_a0 : sel_data;
    assign wb_clear_valid        = retire;
    assign wb_clear_rd           = rd_q;
    assign ecall_request         = (state_q == FULL && is_ecall_q) || state_q == ECALL_WAIT;
    assign retire_pulse          = retire;
    assign retire_count          = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            alu_q       <= '0;
            load_q      <= '0;
            pc4_q       <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= 2'd0;
            is_ecall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (capture) begin
                alu_q       <= mem_alu_data;
                load_q      <= mem_load_data;
                pc4_q       <= mem_pc_plus4;
                rd_q        <= mem_rd;
                reg_write_q <= mem_reg_write;
                wb_sel_q    <= mem_wb_sel;
                is_ecall_q  <= mem_is_ecall;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: directed vector table, ecall/reset sequences and a randomized
// run against a transaction-level model; a 4-bit-counter instance checks wrap.
module tb_mem_wb_writeback;
    logic        clk = 1'b0;
    logic        reset, memory_done, mem_reg_write, mem_is_ecall, ecall_done;
    logic [63:0] mem_alu_data, mem_load_data, mem_pc_plus4, ecall_a0;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic        valid, rf_we, wb_clear_valid, ecall_request, retire_pulse;
    logic [4:0]  rf_waddr, wb_clear_rd;
    logic [63:0] rf_wdata, retire_count;
    logic        valid_s, rf_we_s, clr_s, req_s, ret_s;
    logic [4:0]  waddr_s, clr_rd_s;
    logic [63:0] wdata_s;
    logic [3:0]  count_s;
    int          total = 0, passed = 0;

    always #5 clk = ~clk;

    mem_wb_writeback dut (
        .clk(clk), .reset(reset), .memory_done(memory_done), .mem_alu_data(mem_alu_data),
        .mem_load_data(mem_load_data), .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel), .mem_is_ecall(mem_is_ecall),
        .ecall_done(ecall_done), .ecall_a0(ecall_a0), .mem_wb_pipeline_valid(valid),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_clear_valid(wb_clear_valid),
        .wb_clear_rd(wb_clear_rd), .ecall_request(ecall_request), .retire_pulse(retire_pulse),
        .retire_count(retire_count)
    );

    mem_wb_writeback #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .memory_done(memory_done), .mem_alu_data(mem_alu_data),
        .mem_load_data(mem_load_data), .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel), .mem_is_ecall(mem_is_ecall),
        .ecall_done(ecall_done), .ecall_a0(ecall_a0), .mem_wb_pipeline_valid(valid_s),
        .rf_we(rf_we_s), .rf_waddr(waddr_s), .rf_wdata(wdata_s), .wb_clear_valid(clr_s),
        .wb_clear_rd(clr_rd_s), .ecall_request(req_s), .retire_pulse(ret_s),
        .retire_count(count_s)
    );

    typedef struct {
        logic        md;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        rw;
        logic [63:0] alu, ld, pc4;
        logic        v, we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        ret;
        logic [63:0] cnt;
    } vec_t;

    localparam logic [63:0] LD = 64'hFFFF_FFFF_FFFF_FF80;
    vec_t tbl[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_we"}, rf_we, 0);
        chk({tag, "_waddr"}, rf_waddr, 0);
        chk({tag, "_wdata"}, rf_wdata, 0);
        chk({tag, "_clr"}, {wb_clear_valid, wb_clear_rd}, 0);
        chk({tag, "_req"}, ecall_request, 0);
        chk({tag, "_ret"}, retire_pulse, 0);
        chk({tag, "_cnt"}, retire_count, 0);
        chk({tag, "_cnt_s"}, count_s, 0);
    endtask

    // Model: one pending instruction, whether it has retired, and whether this is its first cycle
    logic        m_busy, m_ret, m_first, m_ec, m_rw;
    logic [1:0]  m_sel;
    logic [4:0]  m_rd;
    logic [63:0] m_alu, m_ld, m_pc4, m_cnt;

    initial begin
        tbl[0]  = '{1, 0, 5, 1, 'h1234, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 5, 1, 'h1234, 0, 0, 1, 1, 5, 'h1234, 1, 0};
        tbl[2]  = '{1, 0, 5, 1, 'h1234, 0, 0, 1, 0, 5, 'h1234, 0, 1};
        tbl[3]  = '{0, 0, 5, 1, 'h1234, 0, 0, 1, 0, 5, 'h1234, 0, 1};
        tbl[4]  = '{1, 1, 6, 1, 'h999, LD, 0, 0, 0, 5, 'h1234, 0, 1};
        tbl[5]  = '{0, 0, 9, 0, 'h999, 0, 0, 1, 1, 6, LD, 1, 1};
        tbl[6]  = '{0, 0, 9, 0, 'h999, 0, 0, 1, 0, 6, LD, 0, 2};
        tbl[7]  = '{1, 2, 1, 1, 'h999, 0, 'h8000_0004, 0, 0, 6, LD, 0, 2};
        tbl[8]  = '{0, 0, 9, 0, 0, 0, 0, 1, 1, 1, 'h8000_0004, 1, 2};
        tbl[9]  = '{0, 0, 9, 0, 0, 0, 0, 1, 0, 1, 'h8000_0004, 0, 3};
        tbl[10] = '{1, 0, 0, 1, 'h55, 0, 0, 0, 0, 1, 'h8000_0004, 0, 3};
        tbl[11] = '{1, 0, 0, 1, 'h55, 0, 0, 1, 0, 0, 'h55, 1, 3};
        tbl[12] = '{1, 0, 0, 1, 'h55, 0, 0, 1, 0, 0, 'h55, 0, 4};
        tbl[13] = '{1, 0, 0, 1, 'h55, 0, 0, 1, 0, 0, 'h55, 0, 4};
        tbl[14] = '{1, 0, 0, 1, 'h55, 0, 0, 1, 0, 0, 'h55, 0, 4};
        tbl[15] = '{0, 0, 0, 1, 'h55, 0, 0, 1, 0, 0, 'h55, 0, 4};
        tbl[16] = '{1, 3, 7, 0, 'hABC, 1, 2, 0, 0, 0, 'h55, 0, 4};
        tbl[17] = '{0, 0, 9, 1, 0, 0, 0, 1, 0, 7, 'hABC, 1, 4};
        tbl[18] = '{0, 0, 9, 1, 0, 0, 0, 1, 0, 7, 'hABC, 0, 5};

        reset = 1; memory_done = 0; mem_alu_data = 0; mem_load_data = 0; mem_pc_plus4 = 0;
        mem_rd = 0; mem_reg_write = 0; mem_wb_sel = 0; mem_is_ecall = 0; ecall_done = 0; ecall_a0 = 0;
        step(); step();
        reset = 0;
        #1 chk_all_zero("reset");

        for (int i = 0; i < 19; i++) begin
            memory_done = tbl[i].md; mem_wb_sel = tbl[i].sel; mem_rd = tbl[i].rd;
            mem_reg_write = tbl[i].rw; mem_alu_data = tbl[i].alu; mem_load_data = tbl[i].ld;
            mem_pc_plus4 = tbl[i].pc4; mem_is_ecall = 0; ecall_done = i[0]; ecall_a0 = 64'hDEAD;
            #1;
            chk($sformatf("vec%0d_valid", i), valid, tbl[i].v);
            chk($sformatf("vec%0d_we", i), rf_we, tbl[i].we);
            chk($sformatf("vec%0d_waddr", i), rf_waddr, tbl[i].wa);
            chk($sformatf("vec%0d_wdata", i), rf_wdata, tbl[i].wd);
            chk($sformatf("vec%0d_ret", i), retire_pulse, tbl[i].ret);
            chk($sformatf("vec%0d_clr", i), wb_clear_valid, tbl[i].ret);
            chk($sformatf("vec%0d_req", i), ecall_request, 0);
            chk($sformatf("vec%0d_cnt", i), retire_count, tbl[i].cnt);
            step();
        end

        // ecall to x10, completed after the environment waits; early ecall_done must be ignored
        memory_done = 1; mem_is_ecall = 1; mem_rd = 10; mem_reg_write = 1; mem_wb_sel = 0;
        mem_alu_data = 'h111; ecall_done = 0;
        step();
        memory_done = 0; ecall_done = 1; ecall_a0 = 7;
        #1 chk("ecall_full", {ecall_request, rf_we, retire_pulse}, 3'b100);
        step();
        ecall_done = 0;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("ecall_wait%0d", k), {ecall_request, rf_we, retire_pulse, valid}, 4'b1001);
            step();
        end
        ecall_done = 1;
        #1;
        chk("ecall_done_ctrl", {ecall_request, rf_we, retire_pulse, wb_clear_valid}, 4'b1111);
        chk("ecall_done_waddr", rf_waddr, 10);
        chk("ecall_done_wdata", rf_wdata, 7);
        chk("ecall_done_cnt", retire_count, 5);
        step();
        #1 chk("ecall_drain", {ecall_request, rf_we, retire_pulse, valid}, 4'b0001);
        chk("ecall_drain_cnt", retire_count, 6);
        ecall_done = 0;
        step();

        // reset while waiting on an ecall
        memory_done = 1; mem_is_ecall = 1; mem_rd = 3;
        step();
        memory_done = 0;
        step(); step();
        #1 chk("rst_ew_req", ecall_request, 1);
        reset = 1;
        step();
        reset = 0;
        #1 chk_all_zero("rst_ew");

        {m_busy, m_ret, m_first, m_ec, m_rw, m_sel, m_rd} = '0;
        {m_alu, m_ld, m_pc4, m_cnt} = '0;
        for (int c = 0; c < 800; c++) begin
            logic        ret_now;
            logic [63:0] sel_v, e_wd;
            reset = $urandom_range(0, 249) == 0;
            memory_done = $urandom_range(0, 2) != 0;
            mem_alu_data = {$urandom, $urandom}; mem_load_data = {$urandom, $urandom};
            mem_pc_plus4 = {$urandom, $urandom}; ecall_a0 = {$urandom, $urandom};
            mem_rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
            mem_reg_write = 1'($urandom); mem_wb_sel = 2'($urandom);
            mem_is_ecall = $urandom_range(0, 3) == 0; ecall_done = $urandom_range(0, 2) == 0;
            #1;
            ret_now = m_busy && !m_ret && (m_ec ? (!m_first && ecall_done) : 1'b1);
            sel_v = m_sel == 1 ? m_ld : m_sel == 2 ? m_pc4 : m_alu;
            e_wd = (m_ec && ret_now) ? ecall_a0 : sel_v;
            chk("rnd_valid", valid, m_busy);
            chk("rnd_we", rf_we, ret_now && m_rw && m_rd != 0);
            chk("rnd_waddr", rf_waddr, m_rd);
            chk("rnd_wdata", rf_wdata, e_wd);
            chk("rnd_clr", {wb_clear_valid, wb_clear_rd}, {ret_now, m_rd});
            chk("rnd_req", ecall_request, m_busy && m_ec && !m_ret);
            chk("rnd_ret", retire_pulse, ret_now);
            chk("rnd_cnt", retire_count, m_cnt);
            chk("rnd_cnt_s", count_s, m_cnt[3:0]);
            chk("rnd_small_ctrl", {valid_s, rf_we_s, waddr_s, clr_s, clr_rd_s, req_s, ret_s},
                {m_busy, ret_now && m_rw && m_rd != 0, m_rd, ret_now, m_rd, m_busy && m_ec && !m_ret, ret_now});
            chk("rnd_small_wdata", wdata_s, e_wd);
            if (reset) begin
                {m_busy, m_ret, m_first, m_ec, m_rw, m_sel, m_rd} = '0;
                {m_alu, m_ld, m_pc4, m_cnt} = '0;
            end else begin
                if (!m_busy) begin
                    if (memory_done) begin
                        m_busy = 1; m_ret = 0; m_first = 1; m_ec = mem_is_ecall; m_rw = mem_reg_write;
                        m_sel = mem_wb_sel; m_rd = mem_rd; m_alu = mem_alu_data;
                        m_ld = mem_load_data; m_pc4 = mem_pc_plus4;
                    end
                end else begin
                    if (ret_now) m_ret = 1;
                    else if (m_ret && !memory_done) m_busy = 0;
                    m_first = 0;
                end
                m_cnt = m_cnt + 64'(ret_now);
            end
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
